// File: rtl/irq_request_latch.sv
// irq_request_latch
//
// Captures eight asynchronous request lines and synchronizes them. Requests
// are latched as pending, filtered by an enable mask, and presented as a
// stable 8-bit snapshot to a downstream 8-to-3 priority encoder. The snapshot
// is held until the consumer acknowledges one of its set bits by index.
//
// Build option: define IRQ_EDGE_DETECT_EN for edge-triggered requests, where
// overrun detection is active. Without it, requests are level-sensitive:
// a line that is still high re-sets its pending bit after it is acknowledged,
// and overrun never pulses.
//
// SYNC_STAGES sets the synchronizer depth. Legal values are 2 or 3.

module irq_request_latch #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_in,
   input  logic       mask_wr,
   input  logic [7:0] mask_data,
   input  logic       ack,
   input  logic [2:0] ack_id,
   output logic [7:0] out,
   output logic       valid,
   output logic [7:0] pending,
   output logic [7:0] mask,
   output logic       ack_err,
   output logic       overrun
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                      state, state_next;
   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  s;
   logic [7:0]                  set_bits;
   logic [7:0]                  clr_bits;
   logic [7:0]                  eligible;
   logic                        ack_hit;
   logic [7:0]                  out_next, pending_next, mask_next;
   logic                        valid_next, ack_err_next, overrun_next;
`ifdef IRQ_EDGE_DETECT_EN
   logic [7:0]                  s_d;
`endif

   assign s = sync_q[SYNC_STAGES-1];

   // Synchronizer chain that brings the request lines into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= req_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

`ifdef IRQ_EDGE_DETECT_EN
   // Delayed copy of the synchronized lines, used for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s_d <= '0;
      end else begin
         s_d <= s;
      end
   end
`endif

   // Set and clear terms for the pending register. In edge mode, a set wins
   // over a clear on the same bit. In level mode, the clear wins for one cycle
   // so that an acknowledged line that is still high re-arms on the next edge.
   always_comb begin
      ack_hit  = ack && (state == HOLD) && out[ack_id];
      clr_bits = ack_hit ? (8'b1 << ack_id) : 8'h00;
`ifdef IRQ_EDGE_DETECT_EN
      set_bits     = s & ~s_d;
      overrun_next = |(set_bits & pending & ~clr_bits);
`else
      set_bits     = s & ~clr_bits;
      overrun_next = 1'b0;
`endif
      pending_next = (pending & ~clr_bits) | set_bits;
      ack_err_next = ack && !ack_hit;
      mask_next    = mask_wr ? mask_data : mask;
      eligible     = pending & ~mask;
   end

   // Grant FSM: snapshot the eligible requests in IDLE, then freeze the
   // snapshot in HOLD until one of its bits is acknowledged
   always_comb begin
      state_next = state;
      out_next   = out;
      valid_next = valid;
      case (state)
         IDLE: begin
            if (eligible != 8'h00) begin
               out_next   = eligible;
               valid_next = 1'b1;
               state_next = HOLD;
            end else begin
               out_next   = 8'h00;
               valid_next = 1'b0;
            end
         end
         HOLD: begin
            if (ack_hit) begin
               out_next   = 8'h00;
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            out_next   = 8'h00;
            valid_next = 1'b0;
         end
      endcase
   end

   // State, snapshot, pending, mask and the one-cycle event pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         out     <= 8'h00;
         valid   <= 1'b0;
         pending <= 8'h00;
         mask    <= 8'h00;
         ack_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_next;
         out     <= out_next;
         valid   <= valid_next;
         pending <= pending_next;
         mask    <= mask_next;
         ack_err <= ack_err_next;
         overrun <= overrun_next;
      end
   end

endmodule

// File: tb/tb_irq_request_latch.sv
// Testbench for irq_request_latch.
// Directed stimulus with hand-computed expectations. Each expected grant
// snapshot is queued when its request is issued. A monitor pops the next
// expected value whenever valid rises and compares it with out. The monitor
// also checks that out stays frozen while valid is held high.

module tb_irq_request_latch;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in;
   logic       mask_wr;
   logic [7:0] mask_data;
   logic       ack;
   logic [2:0] ack_id;
   logic [7:0] out;
   logic       valid;
   logic [7:0] pending;
   logic [7:0] mask;
   logic       ack_err;
   logic       overrun;

   int         total = 0;
   int         bad = 0;
   logic [7:0] grant_q[$];

   irq_request_latch #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .mask_wr   (mask_wr),
      .mask_data (mask_data),
      .ack       (ack),
      .ack_id    (ack_id),
      .out       (out),
      .valid     (valid),
      .pending   (pending),
      .mask      (mask),
      .ack_err   (ack_err),
      .overrun   (overrun)
   );

   // 10-time-unit clock
   always #5 clk = ~clk;

   // Advance one rising edge, then settle away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One-cycle pulse on the request lines
   task automatic apply_stimulus(input logic [7:0] req);
      req_in = req;
      step();
      req_in = 8'h00;
   endtask

   task automatic ack_line(input logic [2:0] id);
      ack    = 1'b1;
      ack_id = id;
      step();
      ack    = 1'b0;
   endtask

   task automatic mask_write(input logic [7:0] value);
      mask_wr   = 1'b1;
      mask_data = value;
      step();
      mask_wr   = 1'b0;
   endtask

   // Scoreboard monitor: compare each new grant against the queued expectation
   initial begin : monitor
      logic       valid_prev;
      logic [7:0] held;
      logic [7:0] exp_out;
      valid_prev = 1'b0;
      held       = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            valid_prev = 1'b0;
         end else begin
            if (valid && !valid_prev) begin
               if (grant_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_grant: got out=%h expected no grant", out);
               end else begin
                  exp_out = grant_q.pop_front();
                  check_output("grant_out", out, exp_out);
               end
               held = out;
            end else if (valid && valid_prev) begin
               check_output("grant_stable", out, held);
            end
            valid_prev = valid;
         end
      end
   end

   initial begin : stimulus
      rst       = 1'b1;
      req_in    = 8'h00;
      mask_wr   = 1'b0;
      mask_data = 8'h00;
      ack       = 1'b0;
      ack_id    = 3'd0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check_output("rst_out", out, 8'h00);
      check_output("rst_valid", {7'b0, valid}, 8'h00);
      check_output("rst_pending", pending, 8'h00);
      check_output("rst_mask", mask, 8'h00);
      check_output("rst_ack_err", {7'b0, ack_err}, 8'h00);
      check_output("rst_overrun", {7'b0, overrun}, 8'h00);
      step();
      step();
      check_output("idle_valid", {7'b0, valid}, 8'h00);

      // First grant: the request is sampled at E0, valid asserts at E0+3
      grant_q.push_back(8'h08);
      apply_stimulus(8'h08);
      step();
      step();
      check_output("lat_pending_e2", pending, 8'h08);
      check_output("lat_valid_e2", {7'b0, valid}, 8'h00);
      step();
      check_output("lat_valid_e3", {7'b0, valid}, 8'h01);
      check_output("lat_out_e3", out, 8'h08);
      ack_line(3'd3);
      check_output("ack3_valid", {7'b0, valid}, 8'h00);
      check_output("ack3_pending", pending, 8'h00);
      check_output("ack3_err", {7'b0, ack_err}, 8'h00);

      // Ack and re-grant
      grant_q.push_back(8'h82);
      grant_q.push_back(8'h02);
      apply_stimulus(8'h82);
      step();
      step();
      step();
      check_output("dual_out", out, 8'h82);
      ack_line(3'd7);
      check_output("dual_gap_valid", {7'b0, valid}, 8'h00);
      check_output("dual_gap_pending", pending, 8'h02);
      step();
      check_output("regrant_valid", {7'b0, valid}, 8'h01);
      check_output("regrant_out", out, 8'h02);
      ack_line(3'd1);

      // Mask: a masked request stays pending and is granted after unmasking
      mask_write(8'h02);
      check_output("mask_reg", mask, 8'h02);
      apply_stimulus(8'h02);
      step();
      step();
      step();
      check_output("masked_pending", pending, 8'h02);
      check_output("masked_valid", {7'b0, valid}, 8'h00);
      grant_q.push_back(8'h02);
      mask_write(8'h00);
      check_output("unmask_valid_w", {7'b0, valid}, 8'h00);
      step();
      check_output("unmask_valid", {7'b0, valid}, 8'h01);
      check_output("unmask_out", out, 8'h02);
      ack_line(3'd1);
      check_output("unmask_ack_pending", pending, 8'h00);

      // Ack while IDLE is ignored and flagged
      step();
      ack_line(3'd0);
      check_output("idle_ack_err", {7'b0, ack_err}, 8'h01);
      step();
      check_output("idle_ack_err_end", {7'b0, ack_err}, 8'h00);

      // Rejected ack in HOLD
      grant_q.push_back(8'h10);
      apply_stimulus(8'h10);
      step();
      step();
      step();
      check_output("rej_out_before", out, 8'h10);
      ack_line(3'd2);
      check_output("rej_ack_err", {7'b0, ack_err}, 8'h01);
      check_output("rej_out", out, 8'h10);
      check_output("rej_valid", {7'b0, valid}, 8'h01);
      check_output("rej_pending", pending, 8'h10);
      step();
      check_output("rej_ack_err_end", {7'b0, ack_err}, 8'h00);
      ack_line(3'd4);
      check_output("rej_accept_valid", {7'b0, valid}, 8'h00);

`ifdef IRQ_EDGE_DETECT_EN
      // Overrun: a second rising edge on an already-pending line
      mask_write(8'h20);
      apply_stimulus(8'h20);
      step();
      check_output("ovr_pending_e1", pending, 8'h00);
      step();
      check_output("ovr_pending", pending, 8'h20);
      check_output("ovr_none", {7'b0, overrun}, 8'h00);
      apply_stimulus(8'h20);
      step();
      step();
      check_output("ovr_pulse", {7'b0, overrun}, 8'h01);
      check_output("ovr_pending_kept", pending, 8'h20);
      step();
      check_output("ovr_pulse_end", {7'b0, overrun}, 8'h00);
      grant_q.push_back(8'h20);
      mask_write(8'h00);
      step();
      check_output("ovr_grant_out", out, 8'h20);
      ack_line(3'd5);
      check_output("ovr_ack_pending", pending, 8'h00);
`else
      // Level mode: a held line re-sets its pending bit after it is acknowledged
      grant_q.push_back(8'h20);
      grant_q.push_back(8'h20);
      req_in = 8'h20;
      step();
      step();
      step();
      step();
      check_output("lvl_out", out, 8'h20);
      check_output("lvl_overrun", {7'b0, overrun}, 8'h00);
      ack_line(3'd5);
      check_output("lvl_ack_pending", pending, 8'h00);
      check_output("lvl_ack_valid", {7'b0, valid}, 8'h00);
      step();
      check_output("lvl_reset_pending", pending, 8'h20);
      check_output("lvl_reset_valid", {7'b0, valid}, 8'h00);
      step();
      check_output("lvl_regrant_out", out, 8'h20);
      req_in = 8'h00;
      step();
      step();
      step();
      check_output("lvl_hold_pending", pending, 8'h20);
      ack_line(3'd5);
      check_output("lvl_final_pending", pending, 8'h00);
      step();
      check_output("lvl_idle_pending", pending, 8'h00);
      check_output("lvl_idle_overrun", {7'b0, overrun}, 8'h00);
`endif

      // Reset mid-HOLD with every line pending
      grant_q.push_back(8'hFF);
      apply_stimulus(8'hFF);
      step();
      step();
      step();
      check_output("full_pending", pending, 8'hFF);
      mask_write(8'h01);
      check_output("held_after_mask", out, 8'hFF);
      rst = 1'b1;
      step();
      check_output("mid_rst_out", out, 8'h00);
      check_output("mid_rst_valid", {7'b0, valid}, 8'h00);
      check_output("mid_rst_pending", pending, 8'h00);
      check_output("mid_rst_mask", mask, 8'h00);
      rst = 1'b0;
      step();
      step();
      check_output("post_rst_valid", {7'b0, valid}, 8'h00);

      total++;
      if (grant_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL grants_left: got %0d pending expectations expected 0", grant_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

Upstream companion to the 8-to-3 priority encoder: captures eight asynchronous request lines, synchronizes and edge-detects them, holds them as pending, applies an enable mask, and presents a stable 8-bit snapshot to the encoder's `in` port. The snapshot is held until the consumer acknowledges the serviced line by index, which is the encoder's 3-bit output fed back as `ack_id`. Only that pending bit is cleared; the next snapshot is then presented.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per request line; legal values 2–3.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_in`  input  8  asynchronous request lines; bit 7 is highest priority downstream.
- `mask_wr`  input  1  loads `mask_data` into the mask register.
- `mask_data`  input  8  new mask; bit = 1 disables that line.
- `ack`  input  1  consumer has serviced the line `ack_id`.
- `ack_id`  input  3  index of the serviced line.
- `out`  output  8  masked pending snapshot, wired to the encoder input.
- `valid`  output  1  `out` is non-zero and stable.
- `pending`  output  8  raw pending register, unmasked, for debug.
- `mask`  output  8  current mask register.
- `ack_err`  output  1  one-cycle pulse when an acknowledge is rejected.
- `overrun`  output  1  one-cycle pulse when a rising edge hits an already-pending bit.

## Operation
- **Reset values:** `out`=8'h00, `valid`=0, `pending`=8'h00, `mask`=8'h00 (all lines enabled), `ack_err`=0, `overrun`=0, synchronizer and edge-history flops 0, FSM in IDLE.
- **Synchronizer:** a chain of `SYNC_STAGES` flops per line. `s` is the last stage; `s_d` is `s` delayed by one cycle.
- **Set:** `rise = s & ~s_d`. Each rise bit sets the corresponding `pending` bit, whether or not that line is masked.
- **Clear:** an accepted ack clears `pending[ack_id]`. If a set and a clear hit the same bit in the same cycle, the set wins.
- **Overrun:** pulses when `rise[i]` coincides with `pending[i]`=1 and that bit is not being cleared in the same cycle. The edge is lost.
- **Mask write:** `mask_wr` updates `mask` on the next edge. It never alters an `out` snapshot that is already held.
- **FSM, 2 states:**
  - **IDLE:** if `(pending & ~mask) != 0`, load `out` with that value, set `valid`=1, and move to HOLD. Otherwise `out`=0, `valid`=0.
  - **HOLD:** `out` and `valid` are frozen. On `ack` with `out[ack_id]`=1, the ack is accepted: clear the pending bit, set `valid`=0, set `out`=0, and move to IDLE.
- **Rejected ack:** an ack in HOLD with `out[ack_id]`=0 is rejected. `ack_err` pulses and the state stays HOLD. An ack in IDLE is ignored and `ack_err` pulses.
- `ack_err` and `overrun` are registered and high for exactly one cycle per event.

## Timing
- `req_in` is sampled high at edge E0. `pending` sets at E0+`SYNC_STAGES`. `out`/`valid` assert at E0+`SYNC_STAGES`+1, which is 3 edges with the default.
- An ack accepted at edge A deasserts `valid` at A. The earliest next snapshot is at A+1, so `valid` is low for exactly one cycle between back-to-back grants.
- `out` changes only on IDLE→HOLD and HOLD→IDLE transitions, so the downstream encoder sees a stable input for the whole grant.
- `rst` mid-HOLD returns all state to the reset values on the same edge. Requests already pending are discarded.
- A masked pending bit stays pending. It becomes eligible in the first IDLE cycle after the mask bit is cleared.

## Configuration
- **`IRQ_EDGE_DETECT_EN` defined:** edge-triggered behaviour as described above.
- **`IRQ_EDGE_DETECT_EN` undefined:** level mode.
  - `pending[i]` is set every cycle while `s[i]`=1.
  - An accepted ack clears the bit for one cycle; it re-sets on the following edge if the line is still high.
  - `overrun` is tied to 0.
  - Latency is the same as edge mode.

## Test plan
- **Reset and first grant:** reset, then hold `req_in`=8'h00 → `out`=0, `valid`=0, `mask`=0. Raise `req_in[3]` → `out`=8'h08 and `valid`=1 exactly 3 edges after first sample.
- **Ack and re-grant:** with `req_in` rising edges on bits 7 and 1 in the same cycle → `out`=8'h82. Ack with `ack_id`=7 → `valid` low for one cycle, then `out`=8'h02.
- **Mask:** write mask 8'h02, then pulse `req_in[1]` → `pending`=8'h02, `valid` stays 0. Write mask 8'h00 → `out`=8'h02 two edges later.
- **Rejected ack:** in HOLD with `out`=8'h10, ack with `ack_id`=2 → `ack_err` pulses one cycle, `out` stays 8'h10, `pending` unchanged.
- **Overrun:** with `pending[5]`=1 and no ack, toggle `req_in[5]` low then high → one `overrun` pulse. In level mode, repeat with the line held high; acking bit 5 → the bit re-sets one cycle later.
- **Reset mid-operation:** assert `rst` in HOLD with `pending`=8'hFF → on the next edge all outputs are 0 and the FSM is in IDLE.
